reset_sequencer: RTL

- Consumes the three PLL lock indicators from the clock manager and drives per-domain reset requests for the memory, game and pixel domains.
- Releases the domains in a fixed order with programmable delays: memory first, then game, then pixel.
- Re-asserts every domain reset immediately on loss of lock and supports a game-only soft restart.
- Runs on the 50 MHz reference clock. Each destination domain synchronises deassertion locally.

---
 rtl/clk_rst_pkg.sv | 31 +++
 rtl/rst_delay_counter.sv | 40 ++++
 rtl/reset_sequencer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/clk_rst_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clk_rst_pkg : reset sequencer state encoding and default release delays
// Revision    : 1.0
// ---------------------------------------------------------------------------
package clk_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_MEM_WAIT   = 3'd1,
    ST_GAME_WAIT  = 3'd2,
    ST_PIXEL_WAIT = 3'd3,
    ST_RUN        = 3'd4,
    ST_SOFT_HOLD  = 3'd5
  } seq_state_e;

  localparam int DEF_MEM_DELAY   = 8;
  localparam int DEF_GAME_DELAY  = 4;
  localparam int DEF_PIXEL_DELAY = 4;
  localparam int DEF_SOFT_LEN    = 16;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_LOSS_W      = 8;

  // States in which a lock drop is treated as a loss event.
  function automatic logic state_is_active(input seq_state_e s);
    return (s == ST_MEM_WAIT) || (s == ST_GAME_WAIT) || (s == ST_PIXEL_WAIT) ||
           (s == ST_RUN) || (s == ST_SOFT_HOLD);
  endfunction

endpackage : clk_rst_pkg
`default_nettype wire

// File: rtl/rst_delay_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rst_delay_counter : clearable up-counter with terminal-count flag
// Revision          : 1.0
// ---------------------------------------------------------------------------
module rst_delay_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule : rst_delay_counter
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reset_sequencer : ordered mem -> game -> pixel reset release from PLL locks
// Revision        : 1.0
// ---------------------------------------------------------------------------
module reset_sequencer
  import clk_rst_pkg::*;
#(
  parameter int MEM_DELAY   = DEF_MEM_DELAY,
  parameter int GAME_DELAY  = DEF_GAME_DELAY,
  parameter int PIXEL_DELAY = DEF_PIXEL_DELAY,
  parameter int SOFT_LEN    = DEF_SOFT_LEN,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int LOSS_W      = DEF_LOSS_W
) (
  input  logic              clk_50mhz,
  input  logic              reset,
  input  logic              pixel_locked,
  input  logic              game_locked,
  input  logic              mem_locked,
  input  logic              soft_rst_req,
  output logic              mem_rst,
  output logic              game_rst,
  output logic              pixel_rst,
  output logic              sys_ready,
  output logic [2:0]        seq_state,
  output logic [LOSS_W-1:0] loss_count
);

  localparam logic [CNT_W-1:0] MEM_TERM   = CNT_W'(MEM_DELAY - 1);
  localparam logic [CNT_W-1:0] GAME_TERM  = CNT_W'(GAME_DELAY - 1);
  localparam logic [CNT_W-1:0] PIXEL_TERM = CNT_W'(PIXEL_DELAY - 1);
  localparam logic [CNT_W-1:0] SOFT_TERM  = CNT_W'(SOFT_LEN - 1);

  seq_state_e        state_q, state_d;
  logic              mem_rst_q, mem_rst_d;
  logic              game_rst_q, game_rst_d;
  logic              pixel_rst_q, pixel_rst_d;
  logic              sys_ready_q, sys_ready_d;
  logic [LOSS_W-1:0] loss_count_q, loss_count_d;

  logic              all_locked;
  logic              cnt_clr;
  logic              cnt_en;
  logic [CNT_W-1:0]  cnt_term;
  logic              cnt_tc;

  assign all_locked = pixel_locked & game_locked & mem_locked;

  rst_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay_cnt (
    .clk  (clk_50mhz),
    .rst  (reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (cnt_term),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    mem_rst_d    = mem_rst_q;
    game_rst_d   = game_rst_q;
    pixel_rst_d  = pixel_rst_q;
    sys_ready_d  = sys_ready_q;
    loss_count_d = loss_count_q;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    cnt_term     = '0;

    case (state_q)
      ST_WAIT_LOCK: begin
        mem_rst_d   = 1'b1;
        game_rst_d  = 1'b1;
        pixel_rst_d = 1'b1;
        sys_ready_d = 1'b0;
        cnt_clr     = 1'b1;
        if (all_locked) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        cnt_term = MEM_TERM;
        if (cnt_tc) begin
          mem_rst_d = 1'b0;
          cnt_clr   = 1'b1;
          state_d   = ST_GAME_WAIT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_GAME_WAIT: begin
        cnt_term = GAME_TERM;
        if (cnt_tc) begin
          game_rst_d = 1'b0;
          cnt_clr    = 1'b1;
          state_d    = ST_PIXEL_WAIT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_PIXEL_WAIT: begin
        cnt_term = PIXEL_TERM;
        if (cnt_tc) begin
          pixel_rst_d = 1'b0;
          sys_ready_d = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = ST_RUN;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_clr = 1'b1;
        if (soft_rst_req) begin
          game_rst_d  = 1'b1;
          pixel_rst_d = 1'b1;
          sys_ready_d = 1'b0;
          state_d     = ST_SOFT_HOLD;
        end
      end
      ST_SOFT_HOLD: begin
        cnt_term = SOFT_TERM;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = ST_GAME_WAIT;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        mem_rst_d   = 1'b1;
        game_rst_d  = 1'b1;
        pixel_rst_d = 1'b1;
        sys_ready_d = 1'b0;
        cnt_clr     = 1'b1;
        state_d     = ST_WAIT_LOCK;
      end
    endcase

    // Lock loss overrides both delay expiry and a pending soft restart.
    if (state_is_active(state_q) && !all_locked) begin
      mem_rst_d   = 1'b1;
      game_rst_d  = 1'b1;
      pixel_rst_d = 1'b1;
      sys_ready_d = 1'b0;
      cnt_clr     = 1'b1;
      cnt_en      = 1'b0;
      state_d     = ST_WAIT_LOCK;
      if (loss_count_q != {LOSS_W{1'b1}}) loss_count_d = loss_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      state_q      <= ST_WAIT_LOCK;
      mem_rst_q    <= 1'b1;
      game_rst_q   <= 1'b1;
      pixel_rst_q  <= 1'b1;
      sys_ready_q  <= 1'b0;
      loss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_rst_q    <= mem_rst_d;
      game_rst_q   <= game_rst_d;
      pixel_rst_q  <= pixel_rst_d;
      sys_ready_q  <= sys_ready_d;
      loss_count_q <= loss_count_d;
    end
  end

  assign mem_rst    = mem_rst_q;
  assign game_rst   = game_rst_q;
  assign pixel_rst  = pixel_rst_q;
  assign sys_ready  = sys_ready_q;
  assign seq_state  = state_q;
  assign loss_count = loss_count_q;

endmodule : reset_sequencer
`default_nettype wire
